// File: rtl/ddp_hdr_framer_if.sv
// Signal bundle around the header framer: RDMAP header strobe in, 32-bit DDP word stream out.
// master is the framer's view (consumes headers, drives words); slave is the surrounding logic.
interface ddp_hdr_framer_if;
  logic [55:0] rdmap2DdpHeader;
  logic [7:0]  rdmap2DdpCtrl;
  logic        rdmap2DdpHdrValid;
  logic [31:0] ddpData;
  logic        ddpValid;
  logic        ddpSop;
  logic        ddpEop;
  logic        ddpReady;

  modport master (
    input  rdmap2DdpHeader,
    input  rdmap2DdpCtrl,
    input  rdmap2DdpHdrValid,
    output ddpData,
    output ddpValid,
    output ddpSop,
    output ddpEop,
    input  ddpReady
  );

  modport slave (
    output rdmap2DdpHeader,
    output rdmap2DdpCtrl,
    output rdmap2DdpHdrValid,
    input  ddpData,
    input  ddpValid,
    input  ddpSop,
    input  ddpEop,
    output ddpReady
  );
endinterface

// File: rtl/ddp_hdr_framer.sv
// Queues RDMAP headers in a small FIFO and frames each one, stamped with a 16-bit MSN,
// as a 2-word (SEND) or 3-word frame on a valid/ready 32-bit stream.
module ddp_hdr_framer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic            clock,
  input  logic            reset,
  ddp_hdr_framer_if.master bus,
  output logic [CW-1:0]   hdrFifoCount,
  output logic            hdrOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] W0   = 2'd1;
  localparam logic [1:0] W1   = 2'd2;
  localparam logic [1:0] W2   = 2'd3;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [15:0]   msn;
  logic [7:0]    cur_ctrl;
  logic [55:0]   cur_hdr;

  logic          push;
  logic          pop;
  logic          accept;
  logic          cur_send;
  logic          frame_done;
  logic [63:0]   head;
  logic [15:0]   msn_start;

  function automatic logic is_send(input logic [7:0] ctrl);
    return ctrl[3:0] == 4'b0000;
  endfunction

  function automatic logic [31:0] word0(input logic [7:0] ctrl, input logic [15:0] seq);
    logic tagged_op;
    tagged_op = (ctrl[3:0] == 4'b0011) || (ctrl[3:0] == 4'b0111);
    return {ctrl, tagged_op, 7'd0, seq};
  endfunction

  // Full test uses the registered count only, so a same-cycle pop never makes room for a push.
  always_comb begin
    push       = bus.rdmap2DdpHdrValid && (hdrFifoCount != FULL);
    accept     = bus.ddpValid && bus.ddpReady;
    cur_send   = is_send(cur_ctrl);
    frame_done = accept && (((state == W1) && cur_send) || (state == W2));
    pop        = (hdrFifoCount != '0) && ((state == IDLE) || frame_done);
    head       = mem[rd_ptr];
    // A frame started on the closing edge of the previous one carries the incremented MSN.
    msn_start  = frame_done ? (msn + 16'd1) : msn;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {bus.rdmap2DdpCtrl, bus.rdmap2DdpHeader};
    end
    if (pop) begin
      cur_ctrl <= head[63:56];
      cur_hdr  <= head[55:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hdrFifoCount <= '0;
      hdrOverflow  <= 1'b0;
      state        <= IDLE;
      msn          <= '0;
      bus.ddpData  <= '0;
      bus.ddpValid <= 1'b0;
      bus.ddpSop   <= 1'b0;
      bus.ddpEop   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bus.rdmap2DdpHdrValid && (hdrFifoCount == FULL)) begin
        hdrOverflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   hdrFifoCount <= hdrFifoCount + CW'(1);
        2'b01:   hdrFifoCount <= hdrFifoCount - CW'(1);
        default: hdrFifoCount <= hdrFifoCount;
      endcase

      if (frame_done) begin
        msn <= msn + 16'd1;
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + AW'(1);
        state        <= W0;
        bus.ddpData  <= word0(head[63:56], msn_start);
        bus.ddpValid <= 1'b1;
        bus.ddpSop   <= 1'b1;
        bus.ddpEop   <= 1'b0;
      end else if (frame_done) begin
        state        <= IDLE;
        bus.ddpValid <= 1'b0;
        bus.ddpSop   <= 1'b0;
        bus.ddpEop   <= 1'b0;
      end else if (accept) begin
        case (state)
          W0: begin
            state       <= W1;
            bus.ddpData <= cur_hdr[55:24];
            bus.ddpSop  <= 1'b0;
            bus.ddpEop  <= cur_send;
          end
          W1: begin
            state       <= W2;
            bus.ddpData <= {cur_hdr[23:0], 8'h00};
            bus.ddpEop  <= 1'b1;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddp_hdr_framer.sv
// Bench for ddp_hdr_framer: fixed vector table, corner-case sequences and randomized traffic
// compared every cycle against a header-queue / word-queue reference model.
module tb_ddp_hdr_framer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] hdrFifoCount;
  logic          hdrOverflow;

  ddp_hdr_framer_if bus();

  always #5 clock = ~clock;

  ddp_hdr_framer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .hdrFifoCount (hdrFifoCount),
    .hdrOverflow  (hdrOverflow)
  );

  typedef struct packed { logic [31:0] data; logic sop; logic eop; } word_t;
  typedef struct packed { logic [7:0] ctrl; logic [55:0] hdr; } entry_t;
  typedef struct {
    logic v; logic [7:0] c; logic [55:0] h; logic r;
    logic ev; logic [31:0] ed; logic es; logic ee; int ecnt;
  } vec_t;

  entry_t      m_q[$];
  word_t       m_words[$];
  logic [15:0] m_msn = '0;
  logic        m_ovf = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a header becomes the list of words it will put on the wire.
  function automatic void model_load(input entry_t e);
    logic [3:0] op;
    logic       t;
    word_t      w;
    op = e.ctrl[3:0];
    t  = (op == 4'b0011) || (op == 4'b0111);
    w.data = {e.ctrl, t, 7'd0, m_msn}; w.sop = 1'b1; w.eop = 1'b0;
    m_words.push_back(w);
    w.data = e.hdr[55:24]; w.sop = 1'b0; w.eop = (op == 4'b0000);
    m_words.push_back(w);
    if (op != 4'b0000) begin
      w.data = {e.hdr[23:0], 8'h00}; w.sop = 1'b0; w.eop = 1'b1;
      m_words.push_back(w);
    end
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] c, input logic [55:0] h,
                                     input logic r, input logic rn);
    int     n0;
    word_t  w;
    entry_t e;
    if (!rn) begin
      m_q.delete();
      m_words.delete();
      m_msn = '0;
      m_ovf = 1'b0;
      return;
    end
    n0 = m_q.size();
    if (m_words.size() > 0 && r) begin
      w = m_words.pop_front();
      if (w.eop) m_msn = m_msn + 16'd1;
    end
    if (m_words.size() == 0 && n0 > 0) model_load(m_q.pop_front());
    if (v) begin
      if (n0 < DEPTH) begin
        e.ctrl = c; e.hdr = h;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic compare_model();
    check("model valid", bus.ddpValid, m_words.size() > 0);
    if (m_words.size() > 0) begin
      check("model data", bus.ddpData, m_words[0].data);
      check("model sop", bus.ddpSop, m_words[0].sop);
      check("model eop", bus.ddpEop, m_words[0].eop);
    end
    check("model count", hdrFifoCount, m_q.size());
    check("model overflow", hdrOverflow, m_ovf);
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic [55:0] h,
                      input logic r, input logic rn, input logic chk);
    bus.rdmap2DdpHdrValid = v;
    bus.rdmap2DdpCtrl     = c;
    bus.rdmap2DdpHeader   = h;
    bus.ddpReady          = r;
    reset                 = rn;
    @(posedge clock);
    #1;
    model_step(v, c, h, r, rn);
    if (chk) compare_model();
  endtask

  vec_t        vt[9];
  logic [7:0]  ovf_ctrl[6];
  logic [15:0] sop_msn[4];
  int          nfr;
  logic        done;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rdmap2DdpHdrValid = 1'b0;
    bus.rdmap2DdpCtrl     = '0;
    bus.rdmap2DdpHeader   = '0;
    bus.ddpReady          = 1'b0;

    // Reset state
    step(0, 8'h00, '0, 0, 0, 0);
    step(0, 8'h00, '0, 0, 0, 0);
    check("reset valid", bus.ddpValid, 0);
    check("reset sop", bus.ddpSop, 0);
    check("reset eop", bus.ddpEop, 0);
    check("reset data", bus.ddpData, 0);
    check("reset count", hdrFifoCount, 0);
    check("reset overflow", hdrOverflow, 0);

    // Single ACK then single SEND, ddpReady held high
    vt[0] = '{1, 8'h07, 56'hAABBCCDDEEFF11, 1, 0, 32'h0,        0, 0, 1};
    vt[1] = '{0, 8'h00, 56'h0,             1, 1, 32'h07800000, 1, 0, 0};
    vt[2] = '{0, 8'h00, 56'h0,             1, 1, 32'hAABBCCDD, 0, 0, 0};
    vt[3] = '{0, 8'h00, 56'h0,             1, 1, 32'hEEFF1100, 0, 1, 0};
    vt[4] = '{1, 8'h00, 56'h5A000000000000, 1, 0, 32'h0,       0, 0, 1};
    vt[5] = '{0, 8'h00, 56'h0,             1, 1, 32'h00000001, 1, 0, 0};
    vt[6] = '{0, 8'h00, 56'h0,             1, 1, 32'h5A000000, 0, 1, 0};
    vt[7] = '{0, 8'h00, 56'h0,             1, 0, 32'h0,        0, 0, 0};
    vt[8] = '{0, 8'h00, 56'h0,             1, 0, 32'h0,        0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].v, vt[i].c, vt[i].h, vt[i].r, 1, 0);
      check($sformatf("vec%0d valid", i), bus.ddpValid, vt[i].ev);
      check($sformatf("vec%0d count", i), hdrFifoCount, vt[i].ecnt);
      if (vt[i].ev) begin
        check($sformatf("vec%0d data", i), bus.ddpData, vt[i].ed);
        check($sformatf("vec%0d sop", i), bus.ddpSop, vt[i].es);
        check($sformatf("vec%0d eop", i), bus.ddpEop, vt[i].ee);
      end
    end

    // Backpressure held for 5 cycles on word1 of an RCV frame
    step(1, 8'h01, 56'h0123456789ABCD, 1, 1, 1);
    step(0, 8'h00, '0, 1, 1, 1);
    check("bp word0", bus.ddpData, 32'h01000002);
    step(0, 8'h00, '0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, '0, 0, 1, 1);
      check("bp hold data", bus.ddpData, 32'h01234567);
      check("bp hold sop", bus.ddpSop, 0);
      check("bp hold eop", bus.ddpEop, 0);
    end
    step(0, 8'h00, '0, 1, 1, 1);
    check("bp word2", bus.ddpData, 32'h89ABCD00);
    check("bp word2 eop", bus.ddpEop, 1);
    step(0, 8'h00, '0, 1, 1, 1);

    // Overflow: six back-to-back strobes with the output stalled
    step(0, 8'h00, '0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      ovf_ctrl[i] = (i % 2 == 1) ? 8'h07 : 8'h00;
      step(1, ovf_ctrl[i], {8'(i), 48'h1234}, 0, 1, 1);
    end
    step(0, 8'h00, '0, 0, 1, 1);
    check("ovf count", hdrFifoCount, 4);
    check("ovf flag", hdrOverflow, 1);
    nfr  = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.ddpValid && bus.ddpSop) begin
        check("ovf frame msn", bus.ddpData[15:0], 16'(nfr));
        if (nfr < 6) check("ovf frame ctrl", bus.ddpData[31:24], ovf_ctrl[nfr]);
        nfr++;
      end
      if (!bus.ddpValid && hdrFifoCount == 0) done = 1'b1;
      else step(0, 8'h00, '0, 1, 1, 1);
    end
    check("ovf drained", done, 1);
    check("ovf frames", nfr, 5);
    check("ovf sticky", hdrOverflow, 1);

    // MSN wrap: preload FFFF, then two SEND frames
    force dut.msn = 16'hFFFF;
    step(0, 8'h00, '0, 1, 1, 0);
    release dut.msn;
    m_msn = 16'hFFFF;
    step(1, 8'h00, 56'h11000000000000, 1, 1, 1);
    step(1, 8'h00, 56'h22000000000000, 1, 1, 1);
    nfr  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (bus.ddpValid && bus.ddpSop) begin
        if (nfr < 4) sop_msn[nfr] = bus.ddpData[15:0];
        nfr++;
      end
      if (!bus.ddpValid && hdrFifoCount == 0) done = 1'b1;
      else step(0, 8'h00, '0, 1, 1, 1);
    end
    check("wrap frames", nfr, 2);
    check("wrap msn first", sop_msn[0], 16'hFFFF);
    check("wrap msn second", sop_msn[1], 16'h0000);

    // Reset in W1 with headers still queued (overflow is still set here)
    step(1, 8'h07, 56'hA1A2A3A4A5A6A7, 0, 1, 1);
    step(1, 8'h00, 56'hB1B2B3B4B5B6B7, 0, 1, 1);
    step(1, 8'h01, 56'hC1C2C3C4C5C6C7, 1, 1, 1);
    check("pre-reset in word1", bus.ddpData, 32'hA1A2A3A4);
    step(0, 8'h00, '0, 1, 0, 1);
    check("midreset valid", bus.ddpValid, 0);
    check("midreset count", hdrFifoCount, 0);
    check("midreset overflow", hdrOverflow, 0);
    step(0, 8'h00, '0, 1, 1, 1);
    step(0, 8'h00, '0, 1, 1, 1);
    check("midreset no words", bus.ddpValid, 0);
    step(1, 8'h00, 56'h33000000000000, 1, 1, 1);
    step(0, 8'h00, '0, 1, 1, 1);
    check("midreset msn0 word0", bus.ddpData, 32'h00000000);
    check("midreset msn0 sop", bus.ddpSop, 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [7:0]  c;
      logic [55:0] h;
      logic        v;
      logic        r;
      logic        rn;
      c = 8'($urandom);
      case ($urandom_range(0, 4))
        0: c[3:0] = 4'b0000;
        1: c[3:0] = 4'b0001;
        2: c[3:0] = 4'b0011;
        3: c[3:0] = 4'b0111;
        default: ;
      endcase
      h  = {24'($urandom), 32'($urandom)};
      v  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 70);
      rn = ($urandom_range(0, 499) != 0);
      step(v, c, h, r, rn, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddp_hdr_framer.md
# ddp_hdr_framer

Consumes the RDMAP header stream (56-bit header, 8-bit control, single-cycle valid, no backpressure) and frames it into 32-bit words for the DDP transmit path. Each header is queued in a small FIFO, stamped with a 16-bit message sequence number (MSN), and emitted as a 2- or 3-word frame on a valid/ready stream. It sits directly downstream of the RDMAP header generator and upstream of the DDP segment/transmit logic.

## Interface
- DEPTH, 4: header FIFO entries (power of two, 2..16)
- CW, 3: width of hdrFifoCount (log2(DEPTH)+1)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- rdmap2DdpHeader  in  56  RDMAP header, sampled when rdmap2DdpHdrValid=1
- rdmap2DdpCtrl  in  8  RDMAP control; [3:0] opcode (0000 SEND, 0001 RCV, 0011 REQ, 0111 ACK)
- rdmap2DdpHdrValid  in  1  one-cycle header strobe; may be asserted back-to-back
- ddpData  out  32  frame word
- ddpValid  out  1  ddpData valid
- ddpSop  out  1  first word of frame
- ddpEop  out  1  last word of frame
- ddpReady  in  1  downstream accepts word when ddpValid&ddpReady
- hdrFifoCount  out  CW  current FIFO occupancy
- hdrOverflow  out  1  sticky: a header was dropped because the FIFO was full

## Operation
- FIFO entry = {ctrl[7:0], header[55:0]}. Write when rdmap2DdpHdrValid=1 and count<DEPTH. If count==DEPTH the header is dropped and hdrOverflow set; cleared only by reset.
- Full test uses the count at that cycle; a pop in the same cycle does not free space for a write (no bypass).
- Simultaneous push and pop with 0<count<DEPTH: count unchanged.
- Pointers wrap modulo DEPTH.
- Frame format (MSN = value at frame start):
  - word0 = {ctrl[7:0], T, 7'd0, msn[15:0]}; T=1 for REQ and ACK, else 0
  - word1 = header[55:24]
  - word2 = {header[23:0], 8'd0}; omitted for SEND (opcode 0000), where word1 is EOP
- FSM states: IDLE, W0, W1, W2.
  - IDLE: count>0 -> pop head into output register, go to W0.
  - W0: accept -> W1.
  - W1: accept -> if SEND: EOP done, else W2.
  - W2: accept -> EOP done.
  - EOP done: msn <= msn+1 (wraps FFFF->0000); if count>0, pop and go to W0 directly (no bubble), else IDLE.
- ddpValid=1 in W0/W1/W2, 0 in IDLE. ddpSop=1 only in W0; ddpEop=1 in W1 for SEND, in W2 otherwise.
- With ddpValid=1 and ddpReady=0, ddpData/ddpSop/ddpEop hold stable.
- RCV and unknown opcodes frame as 3-word, T=0.

## Timing
- Reset values: ddpValid=0, ddpSop=0, ddpEop=0, ddpData=0, hdrFifoCount=0, hdrOverflow=0; msn=0, FSM=IDLE, FIFO empty.
- Reset mid-frame: frame abandoned, no further words, queued headers discarded.
- Latency: strobe in cycle N with empty FIFO and IDLE -> count=1 in N+1 -> word0 valid in N+2.
- Throughput with ddpReady=1: 3 cycles per non-SEND frame, 2 per SEND; sustained input faster than this fills the FIFO.
- hdrFifoCount and hdrOverflow are registered and update the cycle after the causing edge.

## Test plan
- Single ACK, header=56'hAABBCCDDEEFF11, ctrl=8'h07, ddpReady=1 -> cycle N+2: 32'h07800000 SOP; then 32'hAABBCCDD; then 32'hEEFF1100 EOP; msn becomes 1.
- Single SEND, header=56'h5A000000000000, ctrl=8'h00 -> 32'h00000001 (msn=1 from prior) SOP; 32'h5A000000 EOP; exactly 2 words.
- Backpressure: ddpReady=0 for 5 cycles during word1 -> ddpData, ddpSop, ddpEop constant; frame resumes unchanged when ddpReady=1.
- Overflow, DEPTH=4, ddpReady=0: 6 back-to-back strobes -> 1 popped into output register, 4 queued, 6th dropped; hdrFifoCount=4; hdrOverflow=1 and stays 1 after draining; exactly 5 frames emitted in order.
- MSN wrap: force 65537 SEND frames (or preload via backdoor to FFFF) -> word0 carries FFFF then 0000.
- Reset asserted in W1 -> next cycle ddpValid=0, hdrFifoCount=0, hdrOverflow=0; next frame carries msn=0.
